// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write port.
// The master side drives requests; the slave (arbiter) returns grants and drives the rf_* port.
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_w_en;
  logic [ADDR_W-1:0]         rf_rd;
  logic [DATA_W-1:0]         rf_w_data;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, rf_w_en, rf_rd, rf_w_data
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, rf_w_en, rf_rd, rf_w_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional: define RF_WB_X0_DROP_EN to grant rd=0 requests without asserting rf_w_en.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic          clk,
  input  logic          reset,
  rf_wb_arbiter_if.slave wb,
  input  logic          wb_hold,
  output logic [2:0]    grant_id,
  output logic          busy
);

  logic [2:0]         rr_ptr;
  logic [2:0]         winner;
  logic [2:0]         next_ptr;
  logic               found;
  logic               w_en_d;
  logic [NUM_REQ-1:0] ready_c;
  logic [NUM_REQ-1:0] pri_mask;
  logic [NUM_REQ-1:0] valid_hi;
  logic [ADDR_W-1:0]  win_rd;
  logic [DATA_W-1:0]  win_data;
  logic               w_en_q;
  logic [ADDR_W-1:0]  rd_q;
  logic [DATA_W-1:0]  data_q;
  logic [2:0]         grant_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    ready_c  = '0;
    winner   = '0;
    found    = 1'b0;
    win_rd   = '0;
    win_data = '0;
    pri_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) pri_mask[i] = (i >= int'(rr_ptr));
    valid_hi = wb.req_valid & pri_mask;
    if (!reset && !wb_hold) begin
      // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid overall.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (valid_hi[i]) begin
          winner = 3'(i);
          found  = 1'b1;
        end
      end
      if (!found) begin
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
          if (wb.req_valid[i]) begin
            winner = 3'(i);
            found  = 1'b1;
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (found && winner == 3'(i)) begin
          ready_c[i] = 1'b1;
          win_rd     = wb.req_rd[i*ADDR_W +: ADDR_W];
          win_data   = wb.req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign next_ptr = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;

`ifdef RF_WB_X0_DROP_EN
  // x0 writes are consumed but never reach the register file.
  assign w_en_d = found && (win_rd != '0);
`else
  assign w_en_d = found;
`endif

  // NOTE: sequential state uses non-blocking assignments only, with async reset in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_en_q  <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else if (found) begin
      w_en_q  <= w_en_d;
      rd_q    <= win_rd;
      data_q  <= win_data;
      grant_q <= winner;
      rr_ptr  <= next_ptr;
    end else begin
      w_en_q  <= 1'b0;
    end
  end

  assign wb.req_ready = ready_c;
  assign wb.rf_w_en   = w_en_q;
  assign wb.rf_rd     = rd_q;
  assign wb.rf_w_data = data_q;
  assign grant_id     = grant_q;
  assign busy         = (|wb.req_valid) | w_en_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter with a negedge-commit register-file model.
module tb_rf_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic       clk;
  logic       reset;
  logic       wb_hold;
  logic [2:0] grant_id;
  logic       busy;

  int n_checks;
  int n_fails;

  logic [DATA_W-1:0] regs [32];

  rf_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb.slave),
    .wb_hold  (wb_hold),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file commits in the middle of the grant cycle.
  always @(negedge clk) begin
    if (wb.rf_w_en) regs[wb.rf_rd] <= wb.rf_w_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    wb.req_rd[idx*ADDR_W +: ADDR_W]   = rd;
    wb.req_data[idx*DATA_W +: DATA_W] = data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [2:0] exp_order [6];
    n_checks     = 0;
    n_fails      = 0;
    reset        = 1'b1;
    wb_hold      = 1'b0;
    wb.req_valid = 3'b111;
    wb.req_rd    = '0;
    wb.req_data  = '0;
    exp_order    = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};

    // Reset state, with requests pending to show ready is suppressed.
    #2;
    check("rst_ready", 64'(wb.req_ready), 64'(3'b000));
    check("rst_w_en",  64'(wb.rf_w_en), 64'(1'b0));
    check("rst_rd",    64'(wb.rf_rd), 64'(5'd0));
    check("rst_data",  64'(wb.rf_w_data), 64'(32'h0));
    check("rst_grant", 64'(grant_id), 64'(3'd0));
    tick();
    wb.req_valid = 3'b000;
    reset        = 1'b0;
    #1;

    // 1: single request, latency and register-file commit.
    wb.req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    check("t1_ready", 64'(wb.req_ready), 64'(3'b010));
    check("t1_busy",  64'(busy), 64'(1'b1));
    tick();
    check("t1_w_en",  64'(wb.rf_w_en), 64'(1'b1));
    check("t1_rd",    64'(wb.rf_rd), 64'(5'd5));
    check("t1_data",  64'(wb.rf_w_data), 64'(32'hDEADBEEF));
    check("t1_grant", 64'(grant_id), 64'(3'd1));
    wb.req_valid = 3'b000;
    tick();
    check("t1_reg5",   64'(regs[5]), 64'(32'hDEADBEEF));
    check("t1_w_en_0", 64'(wb.rf_w_en), 64'(1'b0));
    check("t1_idle",   64'(busy), 64'(1'b0));

    // 2: all requesters valid from rr_ptr=0 -> fair rotation, no bubbles.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i + 1), 32'(32'h100 + i));
    wb.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t2_ready", 64'(wb.req_ready), 64'(3'b001 << exp_order[k]));
      tick();
      check("t2_grant", 64'(grant_id), 64'(exp_order[k]));
      check("t2_w_en",  64'(wb.rf_w_en), 64'(1'b1));
      check("t2_data",  64'(wb.rf_w_data), 64'(32'h100 + 32'(exp_order[k])));
    end
    wb.req_valid = 3'b000;
    tick();
    check("t2_w_en_0", 64'(wb.rf_w_en), 64'(1'b0));

    // 3: one requester streaming four writes back to back.
    wb.req_valid = 3'b100;
    for (int k = 1; k <= 4; k++) begin
      set_req(2, 5'd7, 32'(k));
      #1;
      check("t3_ready", 64'(wb.req_ready), 64'(3'b100));
      tick();
      check("t3_w_en",  64'(wb.rf_w_en), 64'(1'b1));
      check("t3_data",  64'(wb.rf_w_data), 64'(k));
      check("t3_rd",    64'(wb.rf_rd), 64'(5'd7));
    end
    wb.req_valid = 3'b000;
    tick();
    check("t3_w_en_0", 64'(wb.rf_w_en), 64'(1'b0));
    check("t3_hold_rd", 64'(wb.rf_rd), 64'(5'd7));

    // 4: hold blocks all grants; release grants on the next edge.
    wb_hold      = 1'b1;
    wb.req_valid = 3'b001;
    set_req(0, 5'd3, 32'h33);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_ready_hold", 64'(wb.req_ready), 64'(3'b000));
      tick();
      check("t4_w_en_hold", 64'(wb.rf_w_en), 64'(1'b0));
    end
    wb_hold = 1'b0;
    #1;
    check("t4_ready_rel", 64'(wb.req_ready), 64'(3'b001));
    tick();
    check("t4_w_en_rel", 64'(wb.rf_w_en), 64'(1'b1));
    check("t4_grant",    64'(grant_id), 64'(3'd0));
    check("t4_data",     64'(wb.rf_w_data), 64'(32'h33));

    // 5: write to x0 (rr_ptr=1, so this also exercises the wrap to requester 0).
    set_req(0, 5'd0, 32'h55);
    #1;
    check("t5_ready", 64'(wb.req_ready), 64'(3'b001));
    tick();
`ifdef RF_WB_X0_DROP_EN
    check("t5_w_en", 64'(wb.rf_w_en), 64'(1'b0));
`else
    check("t5_w_en", 64'(wb.rf_w_en), 64'(1'b1));
`endif
    check("t5_rd",    64'(wb.rf_rd), 64'(5'd0));
    check("t5_data",  64'(wb.rf_w_data), 64'(32'h55));
    check("t5_grant", 64'(grant_id), 64'(3'd0));

    // 6: reset during a live write, then restart from rr_ptr=0.
    wb.req_valid = 3'b010;
    set_req(1, 5'd9, 32'hAA);
    tick();
    check("t6_w_en_pre", 64'(wb.rf_w_en), 64'(1'b1));
    check("t6_grant_pre", 64'(grant_id), 64'(3'd1));
    wb.req_valid = 3'b110;
    set_req(2, 5'd10, 32'hBB);
    #1;
    reset = 1'b1;
    #1;
    check("t6_w_en_rst", 64'(wb.rf_w_en), 64'(1'b0));
    check("t6_ready_rst", 64'(wb.req_ready), 64'(3'b000));
    check("t6_grant_rst", 64'(grant_id), 64'(3'd0));
    #1;
    reset = 1'b0;
    #1;
    check("t6_ready_rel", 64'(wb.req_ready), 64'(3'b010));
    tick();
    check("t6_grant1", 64'(grant_id), 64'(3'd1));
    check("t6_data1",  64'(wb.rf_w_data), 64'(32'hAA));
    #1;
    check("t6_ready2", 64'(wb.req_ready), 64'(3'b100));
    tick();
    check("t6_grant2", 64'(grant_id), 64'(3'd2));
    check("t6_data2",  64'(wb.rf_w_data), 64'(32'hBB));
    wb.req_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
